rst_seq_ctrl: RTL

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/rst_debounce.sv | 40 ++++
 rtl/rst_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default timing constants for the reset sequencer.
// Consumed by rst_seq_ctrl and rst_debounce (optional feature macro: RST_SEQ_DEBOUNCE_EN).
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STRETCH   = 2'd2,
    ST_RUN       = 2'd3
  } rst_state_e;

  localparam int unsigned PLL_RST_CYCLES_DEF  = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF    = 65535;
  localparam int unsigned STRETCH_CYCLES_DEF  = 32;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

  localparam logic [3:0] RETRY_MAX = 4'hF;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Key qualifier: output follows the synchronised key level only once that level has
// differed from the output for DEBOUNCE_CYCLES consecutive cycles (used with RST_SEQ_DEBOUNCE_EN).
module rst_debounce
  import rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_sync_i,
  output logic key_qual_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_q, key_d;

  always_comb begin
    cnt_d = '0;
    key_d = key_q;
    if (key_sync_i != key_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) key_d = key_sync_i;
      else                                  cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      key_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  end

  assign key_qual_o = key_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-on / manual reset sequencer: PLL reset, lock wait with retry, stretch, run.
// Optional key debounce enabled by defining RST_SEQ_DEBOUNCE_EN.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES  = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT    = LOCK_TIMEOUT_DEF,
  parameter int unsigned STRETCH_CYCLES  = STRETCH_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       key_n,
  output logic       pll_rst,
  output logic       soc_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [3:0] retry_cnt
);

  localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STRETCH_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  logic lock_meta_q, lock_sync_q;
  logic key_meta_q, key_sync_q;
  logic key_qual, key_prev_q, key_press;

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic             soc_reset_q, soc_reset_d;
  logic             ready_q, ready_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      key_meta_q  <= 1'b1;
      key_sync_q  <= 1'b1;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
      key_meta_q  <= key_n;
      key_sync_q  <= key_meta_q;
    end
  end

`ifdef RST_SEQ_DEBOUNCE_EN
  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .key_sync_i(key_sync_q),
    .key_qual_o(key_qual)
  );
`else
  assign key_qual = key_sync_q;
`endif

  // Edge-detect on the qualified level so a held button fires exactly once.
  assign key_press = key_prev_q & ~key_qual;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (key_press) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_sync_q) begin
            state_d = ST_STRETCH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            if (retry_q != RETRY_MAX) retry_d = retry_q + 4'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STRETCH: begin
          if (!lock_sync_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_sync_q) begin
            state_d = ST_STRETCH;
            cnt_d   = '0;
          end
        end
      endcase
    end
    // Outputs decode the next state so they land in registers alongside it.
    pll_rst_d   = (state_d == ST_PLL_RST);
    soc_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      key_prev_q  <= 1'b1;
      pll_rst_q   <= 1'b1;
      soc_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      key_prev_q  <= key_qual;
      pll_rst_q   <= pll_rst_d;
      soc_reset_q <= soc_reset_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign soc_reset = soc_reset_q;
  assign ready     = ready_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule
